rock_dtop_core: RTL and testbench
=================================

// Module: rock_dtop_core
// PURPOSE
//  Top-level datapath of the ROCK DUT. Elastic streaming buffer with a per-packet checksum.
//  Accepts a valid/ready word stream, buffers it in a FIFO and replays it unchanged downstream.
//  Emits a modular checksum and a packet count on each packet end.
//  Sits directly under the simulation top; it is driven and observed by the cocotb environment.
// PARAMETERS
//  DATA_W      16  stream word width, in bits
//  FIFO_DEPTH  8   buffer depth in words; power of two, >= 2
//  CNT_W       16  width of the packet counter
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            upstream word valid
//  in_ready   out  1            block can accept a word
//  in_data    in   DATA_W       upstream word
//  in_last    in   1            word is the final word of its packet
//  out_valid  out  1            downstream word valid
//  out_ready  in   1            downstream accepts the word
//  out_data   out  DATA_W       downstream word
//  out_last   out  1            packet-end flag, carried with its word
//  out_par    out  1            even-parity bit of out_data (optional feature)
//  sum        out  DATA_W       checksum of the last completed packet
//  sum_valid  out  1            one-cycle pulse when sum updates
//  pkt_count  out  CNT_W        number of completed packets, saturating
// BEHAVIOUR
//  - Interface: one clock, clk; reset is asynchronous and active-high, rst.
//  - Reset: FIFO is emptied and all outputs are 0, including in_ready, out_valid, sum,
//    sum_valid and pkt_count. The checksum accumulator is 0.
//  - Reset release: in_ready rises on the first clk edge after rst deasserts.
//  - Reset mid-operation: all buffered words and any partial packet sum are discarded.
//  - Input handshake: a word is pushed when in_valid && in_ready at a clk edge.
//    in_ready = !full. It depends only on registered state, never on in_valid or out_ready.
//  - Full FIFO: in_ready = 0 even when a pop happens in the same cycle (no pass-through when full).
//  - Output handshake: first-word-fall-through.
//    out_valid = !empty. out_data, out_last and out_par come from the FIFO head.
//    A pop occurs when out_valid && out_ready.
//  - Stability: while out_valid && !out_ready, the head word and its flags stay stable.
//  - Latency: a word pushed at edge N is visible on the output after edge N; there is no
//    same-cycle bypass when the FIFO is empty.
//  - Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//    An extra wrap bit distinguishes full from empty.
//  - Checksum: computed on popped words. acc_next = (acc + out_data) mod 2^DATA_W.
//  - Popping a word with out_last = 1:
//    - sum <= acc + out_data, including that word;
//    - sum_valid pulses high for exactly one cycle;
//    - acc <= 0;
//    - pkt_count increments, saturating at 2^CNT_W - 1.
//  - Between packet ends, sum holds its last value and sum_valid is 0.
//  - A packet may be one word long, with in_last set on its only word.
//  - Packets are never reordered or dropped; data is bit-exact end to end.
// CONFIGURATION
//  - ROCK_PARITY_EN defined: one parity bit per entry is computed at push (^in_data),
//    stored alongside the word and driven on out_par.
//  - ROCK_PARITY_EN undefined: out_par is tied to 0, no parity storage is built, and all
//    other behaviour is identical.
// TESTING
//  - Reset: assert rst mid-stream with 3 words buffered.
//    -> out_valid=0, in_ready=0, pkt_count=0 immediately; in_ready=1 one edge after release.
//  - Single packet: push 0x0001, 0x0002, 0x0003 (last) with out_ready=1.
//    -> same words out in order; sum=0x0006; sum_valid pulses once; pkt_count=1.
//  - Fill/backpressure: out_ready=0, push 9 words.
//    -> 8 are accepted and in_ready=0; raise out_ready and all 8 drain in order.
//  - Wrap and overflow: send 0xFFFF, 0x0002 (last).
//    -> sum=0x0001; over 20 packets the pointers wrap with no loss.
//  - Simultaneous push and pop at half full for 50 cycles -> occupancy constant at 4 words.
//  - ROCK_PARITY_EN: push 0x0007 -> out_par=1; push 0x0003 -> out_par=0.
//    Undefined: out_par=0 for both words.

Source files
------------

// File: rtl/rock_dtop_core.sv
// Elastic streaming buffer: first-word-fall-through FIFO with per-packet modular checksum and packet count.
// Optional feature: define ROCK_PARITY_EN to store a parity bit per entry and drive it on out_par.
module rock_dtop_core #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_par,
    output logic [DATA_W-1:0] sum,
    output logic              sum_valid,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic              run_en;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_sum;

    // Wrap bits differ with equal index bits only when the buffer is full.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // run_en holds in_ready low during reset and through the first edge after release.
    assign in_ready  = run_en && !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head_data = mem_data[rd_ptr[AW-1:0]];
    assign head_last = mem_last[rd_ptr[AW-1:0]];
    assign out_data  = out_valid ? head_data : '0;
    assign out_last  = out_valid && head_last;
    assign acc_sum   = acc + head_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= in_data;
            mem_last[wr_ptr[AW-1:0]] <= in_last;
        end
    end

`ifdef ROCK_PARITY_EN
    logic mem_par [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_par[wr_ptr[AW-1:0]] <= ^in_data;
        end
    end

    assign out_par = out_valid && mem_par[rd_ptr[AW-1:0]];
`else
    assign out_par = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            pkt_count <= '0;
        end else begin
            sum_valid <= 1'b0;
            if (pop) begin
                if (head_last) begin
                    acc       <= '0;
                    sum       <= acc_sum;
                    sum_valid <= 1'b1;
                    if (pkt_count != {CNT_W{1'b1}}) begin
                        pkt_count <= pkt_count + CNT_W'(1);
                    end
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_rock_dtop_core.sv
// Directed bench for rock_dtop_core: vector table for handshake/checksum cycles, plus hand
// sequences for fill, pointer wrap, steady push/pop, parity and mid-stream reset.
module tb_rock_dtop_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_par;
    logic [15:0] sum;
    logic        sum_valid;
    logic [15:0] pkt_count;

    int n_chk = 0;
    int n_err = 0;

    rock_dtop_core #(.DATA_W(16), .FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_par(out_par), .sum(sum), .sum_valid(sum_valid), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        il;
        logic        ordy;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        erdy;
        logic [15:0] esum;
        logic        esv;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [15:0] id, input logic il,
                                input logic ordy, input logic ev, input logic [15:0] ed,
                                input logic el, input logic erdy, input logic [15:0] esum,
                                input logic esv, input logic [15:0] ecnt);
        vec_t v;
        v.iv = iv; v.id = id; v.il = il; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.el = el; v.erdy = erdy;
        v.esum = esum; v.esv = esv; v.ecnt = ecnt;
        return v;
    endfunction

    function automatic logic par_of(input logic [15:0] d);
`ifdef ROCK_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    logic [15:0] wd [60];
    logic [15:0] qd[$];
    logic        ql[$];
    logic [15:0] sq[$];
    logic [15:0] macc;
    logic [15:0] ed;
    logic        el;
    int          sent;
    int          cyc;
    logic        p7;
    logic        p3;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        //      iv  id        il ordy ev  ed        el rdy esum      esv cnt
        tbl[0]  = mk(1, 16'h0001, 0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'd0);
        tbl[1]  = mk(1, 16'h0002, 0, 1, 1, 16'h0001, 0, 1, 16'h0000, 0, 16'd0);
        tbl[2]  = mk(1, 16'h0003, 1, 1, 1, 16'h0002, 0, 1, 16'h0000, 0, 16'd0);
        tbl[3]  = mk(0, 16'h0000, 0, 1, 1, 16'h0003, 1, 1, 16'h0000, 0, 16'd0);
        tbl[4]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0006, 1, 16'd1);
        tbl[5]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0006, 0, 16'd1);
        tbl[6]  = mk(1, 16'hFFFF, 0, 1, 0, 16'h0000, 0, 1, 16'h0006, 0, 16'd1);
        tbl[7]  = mk(1, 16'h0002, 1, 1, 1, 16'hFFFF, 0, 1, 16'h0006, 0, 16'd1);
        tbl[8]  = mk(0, 16'h0000, 0, 1, 1, 16'h0002, 1, 1, 16'h0006, 0, 16'd1);
        tbl[9]  = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0001, 1, 16'd2);
        tbl[10] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'd2);
        tbl[11] = mk(1, 16'h0005, 1, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'd2);
        tbl[12] = mk(0, 16'h0000, 0, 1, 1, 16'h0005, 1, 1, 16'h0001, 0, 16'd2);
        tbl[13] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0005, 1, 16'd3);
        tbl[14] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0005, 0, 16'd3);
        tbl[15] = mk(1, 16'h000A, 0, 0, 0, 16'h0000, 0, 1, 16'h0005, 0, 16'd3);
        tbl[16] = mk(1, 16'h000B, 1, 0, 1, 16'h000A, 0, 1, 16'h0005, 0, 16'd3);
        tbl[17] = mk(0, 16'h0000, 0, 0, 1, 16'h000A, 0, 1, 16'h0005, 0, 16'd3);
        tbl[18] = mk(0, 16'h0000, 0, 1, 1, 16'h000A, 0, 1, 16'h0005, 0, 16'd3);
        tbl[19] = mk(0, 16'h0000, 0, 1, 1, 16'h000B, 1, 1, 16'h0005, 0, 16'd3);
        tbl[20] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0015, 1, 16'd4);
        tbl[21] = mk(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 1, 16'h0015, 0, 16'd4);

        // Reset state and release timing
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst sum", sum, 0);
        chk("rst sum_valid", sum_valid, 0);
        chk("rst pkt_count", pkt_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release in_ready before edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("release in_ready after edge", in_ready, 1);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_data = tbl[i].id; in_last = tbl[i].il; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d out_data", i), out_data, tbl[i].ed);
                chk($sformatf("vec%0d out_last", i), out_last, tbl[i].el);
                chk($sformatf("vec%0d out_par", i), out_par, par_of(tbl[i].ed));
            end
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].erdy);
            chk($sformatf("vec%0d sum", i), sum, tbl[i].esum);
            chk($sformatf("vec%0d sum_valid", i), sum_valid, tbl[i].esv);
            chk($sformatf("vec%0d pkt_count", i), pkt_count, tbl[i].ecnt);
        end

        // Fill with backpressure: only 8 of 9 words accepted, then drain in order
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0100 + 16'(i); in_last = (i == 7);
            #1;
            chk($sformatf("fill in_ready w%0d", i), in_ready, (i < 8));
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("full in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain valid w%0d", i), out_valid, 1);
            chk($sformatf("drain data w%0d", i), out_data, 16'h0100 + 16'(i));
            chk($sformatf("drain last w%0d", i), out_last, (i == 7));
            @(negedge clk);
            #1;
        end
        chk("drain empty", out_valid, 0);
        chk("fill sum", sum, 16'h081C);
        chk("fill sum_valid", sum_valid, 1);
        chk("fill pkt_count", pkt_count, 16'd5);

        // 20 three-word packets with random backpressure; scoreboard checks order and sums
        for (int i = 0; i < 60; i++) wd[i] = 16'($urandom);
        sent = 0; macc = '0;
        for (cyc = 0; cyc < 2000 && !(sent == 60 && qd.size() == 0 && sq.size() == 0); cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 60);
            in_data   = (sent < 60) ? wd[sent] : 16'h0000;
            in_last   = (sent % 3 == 2);
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (sum_valid) begin
                if (sq.size() == 0) chk("wrap spurious sum_valid", 1, 0);
                else chk("wrap sum", sum, sq.pop_front());
            end
            if (out_valid && out_ready) begin
                if (qd.size() == 0) begin
                    chk("wrap unexpected word", 1, 0);
                end else begin
                    ed = qd.pop_front();
                    el = ql.pop_front();
                    chk("wrap data", out_data, ed);
                    chk("wrap last", out_last, el);
                    macc = macc + ed;
                    if (el) begin
                        sq.push_back(macc);
                        macc = '0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                qd.push_back(in_data);
                ql.push_back(in_last);
                sent++;
            end
        end
        chk("wrap finished within budget", (cyc < 2000), 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("wrap pkt_count", pkt_count, 16'd25);

        // Steady push/pop at half full: head always lags the input by exactly 4 words
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0200 + 16'(i); in_last = 1'b0;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0204 + 16'(k);
            #1;
            chk($sformatf("steady head c%0d", k), out_data, 16'h0200 + 16'(k));
            chk($sformatf("steady in_ready c%0d", k), in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("steady drained", out_valid, 0);

        // Parity of 0x0007 and 0x0003
`ifdef ROCK_PARITY_EN
        p7 = 1'b1; p3 = 1'b0;
`else
        p7 = 1'b0; p3 = 1'b0;
`endif
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0007;
        @(negedge clk);
        in_data = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("par head 0007", out_data, 16'h0007);
        chk("par 0007", out_par, p7);
        @(negedge clk);
        #1;
        chk("par head 0003", out_data, 16'h0003);
        chk("par 0003", out_par, p3);
        @(negedge clk);
        #1;
        chk("par drained", out_valid, 0);

        // Reset asserted mid-stream with 3 words buffered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0300 + 16'(i); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre-reset out_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst pkt_count", pkt_count, 0);
        chk("midrst sum", sum, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst release in_ready before edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst release in_ready after edge", in_ready, 1);
        chk("midrst words discarded", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
